i2c_cmd_sequencer: RTL and testbench
====================================

// Module: i2c_cmd_sequencer
// PURPOSE
// - Upstream stage of i2c_master: buffers host I2C transactions in a small command FIFO and issues them one at a time.
// - Per transaction: pulses valid_cmd to the master, waits for completion, retries on error with backoff, reports status to the host.
// - Supplies the 16-bit addr / 24-bit data / byte length that the master consumes today as constants.
// PARAMETERS
// DEPTH        4      command FIFO entries; power of 2, >= 2
// RETRY_MAX    2      re-issues after the first failed attempt before reporting failure
// BACKOFF_CYC  64     idle clk cycles between a failed attempt and its re-issue; >= 1
// TIMEOUT_CYC  4096   clk cycles in WAIT without m_done before the attempt counts as failed; >= 2
// PORTS
// clk          in   1    system clock, rising edge
// rst          in   1    asynchronous reset, active-low
// in_valid     in   1    host command valid
// in_ready     out  1    FIFO can accept a command (= !full)
// in_addr      in   16   device/register address; bit 8 = rw as interpreted by the master
// in_data      in   24   write payload, byte 0 in [23:16]
// in_len       in   2    payload bytes 1..3; 0 is stored and issued as 3
// m_valid_cmd  out  1    one-cycle command strobe to the master
// m_addr       out  16   head-of-FIFO address, stable from ISSUE until REPORT
// m_data       out  24   head-of-FIFO payload, stable from ISSUE until REPORT
// m_len        out  8    zero-extended length (1..3)
// m_done       in   1    master transaction-complete pulse
// m_error      in   1    master error flag, sampled only in the cycle m_done=1
// st_valid     out  1    one-cycle status pulse per retired command
// st_ok        out  1    1 = success, 0 = failed after all retries; valid with st_valid
// st_timeout   out  1    last attempt ended by timeout; valid with st_valid
// st_tries     out  2    attempts used minus 1 (0..RETRY_MAX); valid with st_valid
// busy         out  1    FSM not in IDLE, or FIFO not empty
// fifo_count   out  $clog2(DEPTH)+1  entries currently stored
// BEHAVIOUR
// - Reset (rst=0, async): FSM=IDLE, FIFO emptied (pointers/count=0), retry and timer counters 0; all outputs 0 except in_ready=1.
// - FIFO: push when in_valid && in_ready; pop only in REPORT; push+pop in the same cycle leaves count unchanged.
//   Pointers wrap modulo DEPTH; full when count==DEPTH (in_ready=0, in_valid ignored); head data is not read when empty.
// - FSM states: IDLE, ISSUE, WAIT, BACKOFF, REPORT.
//   IDLE:    count!=0 -> ISSUE (next cycle). A command pushed into an empty FIFO reaches m_valid_cmd 2 cycles after acceptance.
//   ISSUE:   m_valid_cmd=1 for exactly this cycle; timer cleared; -> WAIT.
//   WAIT:    timer++ each cycle. m_done && !m_error -> REPORT ok.
//            m_done && m_error, or timer reaching TIMEOUT_CYC-1 without m_done -> fail attempt:
//            tries<RETRY_MAX -> tries++, timer cleared, -> BACKOFF; else -> REPORT fail.
//            m_done and timeout in the same cycle: m_done wins.
//   BACKOFF: timer++; at BACKOFF_CYC-1 -> ISSUE.
//   REPORT:  st_valid=1 with st_ok/st_timeout/st_tries; pop head; tries=0; -> IDLE.
// - m_done outside WAIT is ignored; it neither aborts BACKOFF nor creates status.
// - st_tries never exceeds RETRY_MAX; st_timeout=1 only when st_ok=0.
// - m_addr/m_data/m_len are driven from the FIFO head register. They hold while the entry is in flight; a push never disturbs them.
// - Reset asserted mid-transaction discards every queued and in-flight command with no status pulse.
//   The master must be reset on the same rst.
// TESTING
// - Single write: push addr=16'hAABB, data=24'hCDCDCD, len=3; m_done, m_error=0 after 20 cycles
//   -> one m_valid_cmd, m_len=3, st_valid with st_ok=1, st_tries=0, fifo_count back to 0.
// - Fill: push 5 commands back-to-back, DEPTH=4, master stalled -> in_ready low after 4th, 5th held;
//   commands issue in push order, one status per command.
// - Retry: m_error=1 on first two attempts, 0 on third -> m_valid_cmd pulses spaced >= BACKOFF_CYC apart;
//   status st_ok=1, st_tries=2.
// - Exhaust: m_error=1 on every attempt -> exactly RETRY_MAX+1 strobes, then st_ok=0, st_timeout=0, st_tries=RETRY_MAX.
// - Timeout: never assert m_done -> strobes repeat after TIMEOUT_CYC+BACKOFF_CYC cycles; final st_ok=0, st_timeout=1.
// - Reset mid-WAIT with 3 queued -> all outputs at reset values immediately, fifo_count=0, no st_valid; new push after release issues normally.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Command sequencer in front of i2c_master: queues host transactions, issues them one at a time,
// retries failed attempts after a backoff and reports one status pulse per retired command.
module i2c_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int RETRY_MAX   = 2,
  parameter int BACKOFF_CYC = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_addr,
  input  logic [23:0]              in_data,
  input  logic [1:0]               in_len,
  output logic                     m_valid_cmd,
  output logic [15:0]              m_addr,
  output logic [23:0]              m_data,
  output logic [7:0]               m_len,
  input  logic                     m_done,
  input  logic                     m_error,
  output logic                     st_valid,
  output logic                     st_ok,
  output logic                     st_timeout,
  output logic [1:0]               st_tries,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_LIM = (TIMEOUT_CYC > BACKOFF_CYC) ? TIMEOUT_CYC : BACKOFF_CYC;
  localparam int TMR_W   = $clog2(TMR_LIM) + 1;
  localparam int ENT_W   = 16 + 24 + 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    BACKOFF = 3'd3,
    REPORT  = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [1:0]         tries_reg, tries_next;
  logic               ok_reg, ok_next;
  logic               to_reg, to_next;
  logic [ENT_W-1:0]   head_reg;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   entry_in;
  logic [1:0]         len_store;
  logic               push, pop, load_head;

  // A length of 0 is stored as 3 so the head register always holds a legal byte count.
  assign len_store = (in_len == 2'd0) ? 2'd3 : in_len;
  assign entry_in  = {in_addr, in_data, len_store};

  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign load_head = (state_reg == IDLE) && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= entry_in;
    end
  end

  // Head is captured on the way into ISSUE and held until the next command, so pushes never disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg <= '0;
    end else if (load_head) begin
      head_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      tries_reg <= '0;
      ok_reg    <= 1'b0;
      to_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      tries_reg <= tries_next;
      ok_reg    <= ok_next;
      to_reg    <= to_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    tries_next  = tries_reg;
    ok_next     = ok_reg;
    to_next     = to_reg;
    m_valid_cmd = 1'b0;
    st_valid    = 1'b0;
    pop         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        m_valid_cmd = 1'b1;
        timer_next  = '0;
        state_next  = WAIT;
      end
      WAIT: begin
        timer_next = timer_reg + 1'b1;
        // A completion in the same cycle as the timeout takes priority.
        if (m_done && !m_error) begin
          ok_next    = 1'b1;
          to_next    = 1'b0;
          state_next = REPORT;
        end else if (m_done || (timer_reg == TMR_W'(TIMEOUT_CYC - 1))) begin
          if (tries_reg < 2'(RETRY_MAX)) begin
            tries_next = tries_reg + 1'b1;
            timer_next = '0;
            state_next = BACKOFF;
          end else begin
            ok_next    = 1'b0;
            to_next    = !m_done;
            state_next = REPORT;
          end
        end
      end
      BACKOFF: begin
        timer_next = timer_reg + 1'b1;
        if (timer_reg == TMR_W'(BACKOFF_CYC - 1)) begin
          state_next = ISSUE;
        end
      end
      REPORT: begin
        st_valid   = 1'b1;
        pop        = 1'b1;
        tries_next = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign st_ok      = st_valid && ok_reg;
  assign st_timeout = st_valid && to_reg;
  assign st_tries   = st_valid ? tries_reg : 2'd0;

  assign m_addr     = head_reg[ENT_W-1 -: 16];
  assign m_data     = head_reg[25:2];
  assign m_len      = {6'd0, head_reg[1:0]};

  assign busy       = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: a reactive master model plus command/status scoreboards
// fed at push time and drained when the sequencer strobes or reports.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH       = 4;
  localparam int RETRY_MAX   = 2;
  localparam int BACKOFF_CYC = 64;
  localparam int TIMEOUT_CYC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_addr = '0;
  logic [23:0] in_data = '0;
  logic [1:0]  in_len = '0;
  logic        m_valid_cmd;
  logic [15:0] m_addr;
  logic [23:0] m_data;
  logic [7:0]  m_len;
  logic        m_done = 1'b0;
  logic        m_error = 1'b0;
  logic        st_valid, st_ok, st_timeout;
  logic [1:0]  st_tries;
  logic        busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(
    .DEPTH(DEPTH), .RETRY_MAX(RETRY_MAX), .BACKOFF_CYC(BACKOFF_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_len(in_len),
    .m_valid_cmd(m_valid_cmd), .m_addr(m_addr), .m_data(m_data), .m_len(m_len),
    .m_done(m_done), .m_error(m_error),
    .st_valid(st_valid), .st_ok(st_ok), .st_timeout(st_timeout), .st_tries(st_tries),
    .busy(busy), .fifo_count(fifo_count)
  );

  typedef struct {logic [15:0] addr; logic [23:0] data; logic [7:0] len;} cmd_t;
  typedef struct {logic ok; logic to; logic [1:0] tries; int strobes;} st_t;
  typedef struct {bit silent; bit err; int delay;} resp_t;

  cmd_t  cmd_q[$];
  st_t   st_q[$];
  resp_t resp_q[$];

  int n_checks    = 0;
  int n_errors    = 0;
  int cyc         = 0;
  int lat_exp     = -1;
  int gap_min     = 0;
  int last_strobe = 0;
  int strobes_cur = 0;
  int n_status    = 0;
  int status_mark = 0;
  st_t   mon_e;
  resp_t rsp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: strobes checked against the queued head, statuses popped on st_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (m_valid_cmd) begin
          if (cmd_q.size() == 0) begin
            chk("spurious_strobe", 32'(1), 32'(0));
          end else begin
            chk("m_addr", 32'(m_addr), 32'(cmd_q[0].addr));
            chk("m_data", 32'(m_data), 32'(cmd_q[0].data));
            chk("m_len", 32'(m_len), 32'(cmd_q[0].len));
          end
          if (lat_exp >= 0) begin
            chk("issue_latency", 32'(cyc), 32'(lat_exp));
            lat_exp = -1;
          end
          if (strobes_cur > 0) begin
            chk("retry_gap", 32'((cyc - last_strobe) >= gap_min), 32'(1));
          end
          last_strobe = cyc;
          strobes_cur++;
        end
        if (st_valid) begin
          n_status++;
          if (st_q.size() == 0) begin
            chk("spurious_status", 32'(1), 32'(0));
          end else begin
            mon_e = st_q.pop_front();
            $display("status: addr=%h ok=%0d timeout=%0d tries=%0d strobes=%0d", m_addr,
                     st_ok, st_timeout, st_tries, strobes_cur);
            chk("st_ok", 32'(st_ok), 32'(mon_e.ok));
            chk("st_timeout", 32'(st_timeout), 32'(mon_e.to));
            chk("st_tries", 32'(st_tries), 32'(mon_e.tries));
            chk("strobe_count", 32'(strobes_cur), 32'(mon_e.strobes));
            if (cmd_q.size() > 0) void'(cmd_q.pop_front());
          end
          strobes_cur = 0;
        end
      end
    end
  end

  // Master model: answers each strobe with the next queued response.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid_cmd && rst === 1'b1 && resp_q.size() > 0) begin
        rsp = resp_q.pop_front();
        if (!rsp.silent) begin
          repeat (rsp.delay) @(negedge clk);
          m_done  = 1'b1;
          m_error = rsp.err;
          @(negedge clk);
          m_done  = 1'b0;
          m_error = 1'b0;
        end
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [23:0] d, input logic [1:0] l,
                      input int n_err, input bit silent, input int delay, input bit chk_lat);
    cmd_t  c;
    st_t   s;
    resp_t r;
    int    attempts;
    int    w = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_len   = l;
    while (!in_ready) begin
      @(negedge clk);
      w++;
      if (w > 20000) begin
        chk("push_accept_timeout", 32'(0), 32'(1));
        break;
      end
    end
    if (chk_lat) lat_exp = cyc + 2;
    if (silent) begin
      attempts = RETRY_MAX + 1; s.ok = 1'b0; s.to = 1'b1;
    end else if (n_err <= RETRY_MAX) begin
      attempts = n_err + 1;     s.ok = 1'b1; s.to = 1'b0;
    end else begin
      attempts = RETRY_MAX + 1; s.ok = 1'b0; s.to = 1'b0;
    end
    s.tries   = 2'(attempts - 1);
    s.strobes = attempts;
    c.addr = a;
    c.data = d;
    c.len  = (l == 2'd0) ? 8'd3 : {6'd0, l};
    for (int i = 0; i < attempts; i++) begin
      r.silent = silent;
      r.err    = (i < n_err);
      r.delay  = delay;
      resp_q.push_back(r);
    end
    cmd_q.push_back(c);
    st_q.push_back(s);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int w = 0;
    while ((busy || st_q.size() != 0) && w < limit) begin
      @(negedge clk);
      w++;
    end
    if (w >= limit) chk("idle_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_m_valid_cmd", 32'(m_valid_cmd), 32'(0));
    chk("rst_st_valid", 32'(st_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_fifo_count", 32'(fifo_count), 32'(0));
    chk("rst_m_addr", 32'(m_addr), 32'(0));
    chk("rst_m_len", 32'(m_len), 32'(0));
    rst = 1'b1;
    @(negedge clk);

    // Single write
    push(16'hAABB, 24'hCDCDCD, 2'd3, 0, 1'b0, 20, 1'b1);
    wait_idle(1000);
    chk("single_fifo_count", 32'(fifo_count), 32'(0));
    chk("single_status_seen", 32'(n_status), 32'(1));

    // Fill: master slow, five back-to-back pushes
    push(16'h1000, 24'h000001, 2'd1, 0, 1'b0, 30, 1'b1);
    push(16'h1001, 24'h000002, 2'd2, 0, 1'b0, 30, 1'b0);
    push(16'h1002, 24'h000003, 2'd0, 0, 1'b0, 30, 1'b0);
    push(16'h1003, 24'h000004, 2'd3, 0, 1'b0, 30, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'(0));
    chk("full_fifo_count", 32'(fifo_count), 32'(4));
    chk("full_head_hold", 32'(m_addr), 32'(16'h1000));
    push(16'h1004, 24'h000005, 2'd1, 0, 1'b0, 30, 1'b0);
    wait_idle(2000);
    chk("fill_status_seen", 32'(n_status), 32'(6));

    // Retry: two errors then success
    gap_min = BACKOFF_CYC;
    push(16'h2100, 24'hA1A2A3, 2'd2, 2, 1'b0, 5, 1'b1);
    wait_idle(2000);

    // Exhaust: error on every attempt
    push(16'h2200, 24'hB1B2B3, 2'd3, 3, 1'b0, 7, 1'b1);
    wait_idle(2000);

    // Timeout: master never answers
    gap_min = TIMEOUT_CYC + BACKOFF_CYC;
    push(16'h2300, 24'hC1C2C3, 2'd1, 0, 1'b1, 0, 1'b1);
    wait_idle(20000);
    chk("timeout_fifo_count", 32'(fifo_count), 32'(0));

    // Reset mid-WAIT with three commands queued
    gap_min = 0;
    push(16'h3000, 24'h000010, 2'd1, 0, 1'b1, 0, 1'b0);
    push(16'h3001, 24'h000011, 2'd2, 0, 1'b1, 0, 1'b0);
    push(16'h3002, 24'h000012, 2'd3, 0, 1'b1, 0, 1'b0);
    w = 0;
    while (strobes_cur == 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("pre_reset_strobe_seen", 32'(strobes_cur != 0), 32'(1));
    repeat (5) @(negedge clk);
    chk("pre_reset_fifo_count", 32'(fifo_count), 32'(3));
    status_mark = n_status;
    rst = 1'b0;
    #1;
    chk("mid_rst_fifo_count", 32'(fifo_count), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_m_valid_cmd", 32'(m_valid_cmd), 32'(0));
    chk("mid_rst_st_valid", 32'(st_valid), 32'(0));
    chk("mid_rst_m_addr", 32'(m_addr), 32'(0));
    chk("mid_rst_m_data", 32'(m_data), 32'(0));
    cmd_q.delete();
    st_q.delete();
    resp_q.delete();
    strobes_cur = 0;
    lat_exp     = -1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_no_status", 32'(n_status), 32'(status_mark));
    push(16'h5A5A, 24'h123456, 2'd2, 0, 1'b0, 4, 1'b1);
    wait_idle(1000);
    chk("post_rst_fifo_count", 32'(fifo_count), 32'(0));
    chk("post_rst_status_seen", 32'(n_status), 32'(status_mark + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
